// File: rtl/instr_realigner_if.sv
// instr_realigner_if: fetch-side and instruction-side buses of the instruction
// realigner, plus the redirect (flush) request.
// Ports (signals): flush/flush_pc redirect, fetch_addr/fetch_ready/fetch_valid/
//   fetch_data to instruction memory, instr_valid/instr_ready/instr_out/instr_pc/
//   is_compressed towards the decompressor.
// Modports: master = realigner side, slave = environment (memory + decoder).
interface instr_realigner_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  flush;
  logic [ADDR_WIDTH-1:0] flush_pc;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [31:0]           fetch_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr_out;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  is_compressed;

  modport master (
    input  flush, flush_pc, fetch_valid, fetch_data, instr_ready,
    output fetch_addr, fetch_ready, instr_valid, instr_out, instr_pc, is_compressed
  );

  modport slave (
    output flush, flush_pc, fetch_valid, fetch_data, instr_ready,
    input  fetch_addr, fetch_ready, instr_valid, instr_out, instr_pc, is_compressed
  );
endinterface

// File: rtl/instr_realigner.sv
// instr_realigner: turns word-aligned 32-bit fetch data into a stream of
// instructions (16-bit compressed or 32-bit) with their PCs, ahead of the decompressor.
// Ports: clk, reset (sync, active-high), bus (instr_realigner_if.master):
//   flush/flush_pc redirect, fetch_* word fetch handshake, instr_* instruction handshake.
// Latency: a word accepted at edge N is presented in cycle N+1; outputs depend only on
//   registered state plus the flush/reset/instr_ready inputs, never on fetch_data.
// Optional feature macro RVC_SUPPORT_EN: when defined, a 4-entry halfword FIFO handles
//   compressed and word-straddling instructions; when undefined, a single-word register
//   presents every fetched word as one 32-bit instruction.
module instr_realigner #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  instr_realigner_if.master bus
);

  localparam int unsigned AW = ADDR_WIDTH;
  // Word address the fetch unit restarts from after reset.
  localparam logic [AW-1:0] RESET_WORD = {RESET_PC[AW-1:2], 2'b00};

  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [AW-1:0] instr_pc_q,   instr_pc_d;
  logic          fetch_hs;
  logic          instr_hs;

  assign fetch_hs       = bus.fetch_valid && bus.fetch_ready;
  assign instr_hs       = bus.instr_valid && bus.instr_ready;
  assign bus.fetch_addr = fetch_addr_q;
  assign bus.instr_pc   = instr_pc_q;

`ifdef RVC_SUPPORT_EN

  // Halfword FIFO: hw_q indexed by head_q, count_q holds 0..4 entries.
  logic [15:0] hw_q [4];
  logic [1:0]  head_q,     head_d;
  logic [2:0]  count_q,    count_d;
  // Set after a redirect to an odd-halfword target: the low half of the first
  // fetched word lies before the target and must not enter the FIFO.
  logic        skip_low_q, skip_low_d;

  logic [15:0] h0;
  logic [15:0] h1;
  logic        h0_comp;
  logic        have_instr;
  logic [1:0]  tail;
  logic [1:0]  push_n;
  logic [1:0]  pop_n;

  // flush_pc[0] is meaningless for halfword-aligned targets.
  logic unused_flush_lsb;
  assign unused_flush_lsb = bus.flush_pc[0];

  always_comb begin
    h0         = hw_q[head_q];
    h1         = hw_q[2'(head_q + 2'd1)];
    h0_comp    = (h0[1:0] != 2'b11);
    // A 32-bit instruction needs its upper half too; with one entry left the
    // instruction straddles into the word not yet fetched.
    have_instr = h0_comp ? (count_q != 3'd0) : (count_q >= 3'd2);
    // Accepts only happen with count <= 2, so the two slots past the tail are free
    // even before this cycle's pop is applied.
    tail       = 2'(head_q + count_q[1:0]);
  end

  assign bus.fetch_ready   = !reset && !bus.flush && (count_q <= 3'd2);
  assign bus.instr_valid   = !reset && !bus.flush && have_instr;
  assign bus.instr_out     = h0_comp ? {16'h0000, h0} : {h1, h0};
  assign bus.is_compressed = h0_comp;

  always_comb begin
    head_d       = head_q;
    count_d      = count_q;
    skip_low_d   = skip_low_q;
    fetch_addr_d = fetch_addr_q;
    instr_pc_d   = instr_pc_q;
    push_n       = 2'd0;
    pop_n        = 2'd0;

    if (instr_hs) begin
      pop_n      = h0_comp ? 2'd1 : 2'd2;
      instr_pc_d = instr_pc_q + (h0_comp ? AW'(2) : AW'(4));
    end
    if (fetch_hs) begin
      push_n       = skip_low_q ? 2'd1 : 2'd2;
      skip_low_d   = 1'b0;
      fetch_addr_d = fetch_addr_q + AW'(4);
    end
    head_d  = 2'(head_q + pop_n);
    count_d = count_q + {1'b0, push_n} - {1'b0, pop_n};

    // Redirect: drop everything buffered and restart at the target.
    if (bus.flush) begin
      head_d       = 2'd0;
      count_d      = 3'd0;
      skip_low_d   = bus.flush_pc[1];
      instr_pc_d   = {bus.flush_pc[AW-1:1], 1'b0};
      fetch_addr_d = {bus.flush_pc[AW-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= 2'd0;
      count_q      <= 3'd0;
      skip_low_q   <= RESET_PC[1];
      instr_pc_q   <= RESET_PC;
      fetch_addr_q <= RESET_WORD;
    end else begin
      head_q       <= head_d;
      count_q      <= count_d;
      skip_low_q   <= skip_low_d;
      instr_pc_q   <= instr_pc_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  // Storage needs no reset: count_q decides which entries are meaningful.
  // fetch_ready is low during reset and flush, so fetch_hs never fires then.
  always_ff @(posedge clk) begin
    if (fetch_hs) begin
      if (skip_low_q) begin
        hw_q[tail] <= bus.fetch_data[31:16];
      end else begin
        hw_q[tail]                <= bus.fetch_data[15:0];
        hw_q[2'(tail + 2'd1)]     <= bus.fetch_data[31:16];
      end
    end
  end

`else

  // Single-word holding register: every fetched word is one 32-bit instruction.
  logic [31:0] word_q,       word_d;
  logic        word_valid_q, word_valid_d;

  // Without compressed support every target is treated as word aligned.
  logic unused_flush_lsbs;
  assign unused_flush_lsbs = ^bus.flush_pc[1:0];

  // The register can take a new word when empty or when it drains this cycle.
  assign bus.fetch_ready   = !reset && (!word_valid_q || bus.instr_ready);
  assign bus.instr_valid   = !reset && !bus.flush && word_valid_q;
  assign bus.instr_out     = word_q;
  assign bus.is_compressed = 1'b0;

  always_comb begin
    word_d       = word_q;
    word_valid_d = word_valid_q;
    fetch_addr_d = fetch_addr_q;
    instr_pc_d   = instr_pc_q;

    if (bus.flush) begin
      // A word handed over in the flush cycle belongs to the old path: dropped.
      word_valid_d = 1'b0;
      instr_pc_d   = {bus.flush_pc[AW-1:2], 2'b00};
      fetch_addr_d = {bus.flush_pc[AW-1:2], 2'b00};
    end else begin
      if (instr_hs) begin
        word_valid_d = 1'b0;
        instr_pc_d   = instr_pc_q + AW'(4);
      end
      if (fetch_hs) begin
        word_d       = bus.fetch_data;
        word_valid_d = 1'b1;
        fetch_addr_d = fetch_addr_q + AW'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q       <= 32'h0;
      word_valid_q <= 1'b0;
      instr_pc_q   <= RESET_WORD;
      fetch_addr_q <= RESET_WORD;
    end else begin
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      instr_pc_q   <= instr_pc_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

`endif

endmodule

// File: tb/tb_instr_realigner.sv
// Bench for instr_realigner: random and directed fetch/flush/reset traffic against a
// program-order model of the instruction stream in a sparse memory image.
module tb_instr_realigner;

  localparam int          AW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RVC_SUPPORT_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_realigner_if #(.ADDR_WIDTH(AW)) bus ();

  instr_realigner #(.ADDR_WIDTH(AW), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // ---------------- memory image ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [31:0] w;
    logic [31:0] x;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    x = (w ^ 32'hA5A5_1234) * 32'h9E37_79B1;
    return x ^ (x >> 15);
  endfunction

  function automatic logic [15:0] mem_hw(logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // ---------------- program-order model ----------------
  function automatic bit comp_at(logic [31:0] pc);
    logic [15:0] h;
    h = mem_hw(pc);
    return RVC && (h[1:0] != 2'b11);
  endfunction

  function automatic int size_at(logic [31:0] pc);
    return comp_at(pc) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ins_at(logic [31:0] pc);
    if (!RVC) return mem_word(pc);
    if (comp_at(pc)) return {16'h0000, mem_hw(pc)};
    return {mem_hw(pc + 32'd2), mem_hw(pc)};
  endfunction

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        c;
    logic [31:0] cyc;
  } out_t;

  out_t        lg[$];
  int          acc[$];
  int          cyc_n = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_faddr;

  // Bytes fetched beyond the next PC tell how much of the stream is buffered.
  always @(negedge clk) begin
    int d;
    bit ev;
    bit er;
    cyc_n++;
    if (reset) begin
      chk("reset_instr_valid", bus.instr_valid, 0);
      chk("reset_fetch_ready", bus.fetch_ready, 0);
      exp_pc    = RVC ? RESET_PC : (RESET_PC & ~32'd3);
      exp_faddr = RESET_PC & ~32'd3;
    end else begin
      d = int'(exp_faddr - exp_pc);
      if (d < 0) d = 0;
      ev = !bus.flush && (d >= size_at(exp_pc));
      er = RVC ? (!bus.flush && d <= 4) : (d == 0 || bus.instr_ready);
      chk("fetch_addr",  bus.fetch_addr,  exp_faddr);
      chk("instr_pc",    bus.instr_pc,    exp_pc);
      chk("instr_valid", bus.instr_valid, ev);
      chk("fetch_ready", bus.fetch_ready, er);
      if (ev) begin
        chk("instr_out",     bus.instr_out,     ins_at(exp_pc));
        chk("is_compressed", bus.is_compressed, comp_at(exp_pc));
        if (bus.instr_ready)
          lg.push_back('{ins: bus.instr_out, pc: bus.instr_pc, c: bus.is_compressed, cyc: cyc_n});
      end
      if (bus.flush) begin
        exp_pc    = bus.flush_pc & (RVC ? ~32'd1 : ~32'd3);
        exp_faddr = bus.flush_pc & ~32'd3;
      end else begin
        if (bus.fetch_valid && er) begin
          exp_faddr = exp_faddr + 32'd4;
          acc.push_back(cyc_n);
        end
        if (ev && bus.instr_ready) exp_pc = exp_pc + 32'(size_at(exp_pc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(bit fv, bit rdy, bit fl, logic [31:0] fpc, bit rst);
    @(posedge clk);
    #2;
    reset           = rst;
    bus.flush       = fl;
    bus.flush_pc    = fpc;
    bus.fetch_valid = fv;
    bus.instr_ready = rdy;
    bus.fetch_data  = mem_word(bus.fetch_addr);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    case (r[31:30])
      2'd0:    return 32'hFFFF_FFF0 | (r & 32'hF);
      2'd1:    return r & 32'h0000_03FF;
      default: return r;
    endcase
  endfunction

  task automatic rnd(int n, int fvp, int rdp, int flp);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 99) < fvp, $urandom_range(0, 99) < rdp,
          $urandom_range(0, 99) < flp, rand_pc(), 1'b0);
  endtask

  task automatic chk_out(string nm, int i, logic [31:0] ins, logic [31:0] pc, logic c);
    chk({nm, "_present"}, lg.size() > i, 1);
    if (lg.size() > i) begin
      chk({nm, "_ins"}, lg[i].ins, ins);
      chk({nm, "_pc"},  lg[i].pc,  pc);
      chk({nm, "_c"},   lg[i].c,   c);
    end
  endtask

  logic [31:0] bp_ins [4];
  logic [31:0] bp_pc  [4];

  initial begin
    bus.flush = 1'b0; bus.flush_pc = '0; bus.fetch_valid = 1'b0;
    bus.instr_ready = 1'b0; bus.fetch_data = '0;

    // Aligned 32-bit stream.
    mem[32'h0] = 32'h00A0_0093;
    mem[32'h4] = 32'h0010_8113;
    repeat (2) cyc(0, 0, 0, 0, 1);
    lg.delete(); acc.delete();
    repeat (6) cyc(1, 1, 0, 0, 0);
    chk_out("aligned0", 0, 32'h00A0_0093, 32'h0, 1'b0);
    chk_out("aligned1", 1, 32'h0010_8113, 32'h4, 1'b0);
    if (lg.size() > 0 && acc.size() > 0) chk("aligned_latency", lg[0].cyc, acc[0] + 1);

    // Mixed stream with a 32-bit instruction straddling the word boundary.
    mem[32'h0] = 32'h0093_4529;
    mem[32'h4] = 32'h4529_00A0;
    repeat (2) cyc(0, 0, 0, 0, 1);
    lg.delete();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("straddle_wait_valid", bus.instr_valid, 0);
    chk("straddle_wait_pc", bus.instr_pc, RVC ? 32'h2 : 32'h4);
    repeat (4) cyc(1, 1, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    chk_out("mixed0", 0, RVC ? 32'h0000_4529 : 32'h0093_4529, 32'h0, RVC);
    chk_out("mixed1", 1, RVC ? 32'h00A0_0093 : 32'h4529_00A0, RVC ? 32'h2 : 32'h4, 1'b0);
    chk_out("mixed2", 2, RVC ? 32'h0000_4529 : mem_word(32'h8), RVC ? 32'h6 : 32'h8, RVC);

    // Misaligned redirect, colliding with a presented fetch word.
    mem[32'h100] = 32'h4529_ABCD;
    cyc(1, 1, 1, 32'h102, 0);
    lg.delete();
    cyc(0, 1, 0, 0, 0);
    chk("flush_fetch_addr", bus.fetch_addr, 32'h100);
    chk("flush_bubble_valid", bus.instr_valid, 0);
    repeat (5) cyc(1, 1, 0, 0, 0);
    chk_out("misaligned0", 0, RVC ? 32'h0000_4529 : 32'h4529_ABCD,
            RVC ? 32'h102 : 32'h100, RVC);

    // Backpressure with compressed-only words.
    mem[32'h200] = 32'h1111_2222; mem[32'h204] = 32'h5554_6668;
    mem[32'h208] = 32'h999A_AAAC; mem[32'h20C] = 32'hDDDC_EEE0;
    cyc(0, 0, 1, 32'h200, 0);
    lg.delete();
    repeat (8) cyc(1, 0, 0, 0, 0);
    chk("bp_fetch_ready", bus.fetch_ready, 0);
    chk("bp_instr_valid", bus.instr_valid, 1);
    chk("bp_instr_pc", bus.instr_pc, 32'h200);
    chk("bp_instr_out", bus.instr_out, RVC ? 32'h0000_2222 : 32'h1111_2222);
    repeat (10) cyc(1, 1, 0, 0, 0);
    bp_ins = RVC ? '{32'h2222, 32'h1111, 32'h6668, 32'h5554}
                 : '{32'h1111_2222, 32'h5554_6668, 32'h999A_AAAC, 32'hDDDC_EEE0};
    bp_pc  = RVC ? '{32'h200, 32'h202, 32'h204, 32'h206}
                 : '{32'h200, 32'h204, 32'h208, 32'h20C};
    for (int i = 0; i < 4; i++)
      chk_out($sformatf("bp_drain%0d", i), i, bp_ins[i], bp_pc[i], RVC);
    if (lg.size() > 3) chk("bp_drain_rate", lg[3].cyc, lg[0].cyc + 3);

    // Reset while a 32-bit instruction is half buffered.
    mem[32'h0] = 32'h0093_4529;
    mem[32'h4] = 32'h4529_00A0;
    repeat (2) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    chk("rst_mid_valid", bus.instr_valid, 0);
    mem[32'h0] = 32'h1111_2222;
    cyc(0, 1, 0, 0, 0);
    chk("rst_mid_pc", bus.instr_pc, RESET_PC);
    chk("rst_mid_faddr", bus.fetch_addr, RESET_PC & ~32'd3);
    chk("rst_mid_idle", bus.instr_valid, 0);
    lg.delete();
    repeat (4) cyc(1, 1, 0, 0, 0);
    chk_out("rst_mid0", 0, RVC ? 32'h0000_2222 : 32'h1111_2222, 32'h0, RVC);

    // Randomized traffic, including redirects near the top of the address space.
    rnd(3000, 70, 70, 3);
    rnd(3000, 95, 30, 2);
    rnd(3000, 40, 95, 5);
    repeat (3) cyc(0, 1, 0, 0, 1);
    rnd(1000, 60, 60, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_realigner.md
Name: instr_realigner

Overview:
- Sits directly upstream of the instruction decompressor in the fetch stage.
- Takes 32-bit word-aligned fetch data from instruction memory and buffers it as halfwords.
- Emits one instruction per handshake, either 16-bit compressed or 32-bit, together with its PC and an is_compressed flag.
- Handles 32-bit instructions that straddle a word boundary, misaligned redirect targets and pipeline flushes.

Parameters:
- ADDR_WIDTH, 32, width of all PC and address ports.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be halfword aligned.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  redirect request; highest priority.
- flush_pc  input  ADDR_WIDTH  redirect target; bit 0 is ignored.
- fetch_addr  output  ADDR_WIDTH  word address of the next word to fetch; bits [1:0] are always 0.
- fetch_ready  output  1  realigner can accept a fetch word this cycle.
- fetch_valid  input  1  fetch_data is valid for the current fetch_addr.
- fetch_data  input  32  fetched word; halfword 0 is [15:0].
- instr_valid  output  1  instr_out is valid.
- instr_ready  input  1  downstream consumes instr_out.
- instr_out  output  32  instruction; for compressed, {16'b0, hw}, with [15:0] feeding c_instr.
- instr_pc  output  ADDR_WIDTH  PC of instr_out.
- is_compressed  output  1  instr_out[1:0] != 2'b11; feeds is_compressed of the decompressor.

Behaviour:
- **Buffer:** 4-entry halfword FIFO with a head pointer and a count (0..4) held in registers.
  - Fetch handshake: fetch_valid && fetch_ready.
  - Output handshake: instr_valid && instr_ready.
- **fetch_ready:** equals (count <= 2) && !flush, evaluated on the pre-consume count.
- **Fetch accept:** pushes 2 halfwords and advances fetch_addr by 4.
  - If the skip_low flag is set, only the high halfword is pushed and the flag is cleared.
- **Decode of head halfword h0:**
  - h0[1:0] != 2'b11: compressed; needs count >= 1.
  - Otherwise 32-bit; needs count >= 2, and instr_out = {h1, h0}.
- **instr_valid:** 1 when the needed halfwords are present. Outputs are combinational from registered state only, never from fetch_data.
  - Latency: a word accepted at edge N is visible at instr_out in cycle N+1.
- **Consume:** pops 1 or 2 halfwords and advances instr_pc by 2 or 4.
  - Push and pop in the same cycle are both applied; the count nets correctly.
- **Straddling 32-bit:** with count==1 and h0[1:0]==2'b11, instr_valid stays 0 until the next word arrives.
- **Flush:**
  - FIFO is cleared and instr_pc loads flush_pc.
  - fetch_addr loads {flush_pc[ADDR_WIDTH-1:2], 2'b00}.
  - skip_low is set to flush_pc[1].
  - Any fetch_data presented in the same cycle is dropped.
  - instr_valid is 0 in the flush cycle and the following cycle.
- **Reset:** takes priority over flush.
  - count=0, head=0, skip_low=RESET_PC[1].
  - instr_pc=RESET_PC, fetch_addr={RESET_PC[ADDR_WIDTH-1:2], 2'b00}.
  - instr_valid=0, fetch_ready=0 during the reset cycle.
  - Reset mid-straddle discards the partial instruction.
- **Stall:** with instr_ready=0, instr_out, instr_pc and is_compressed hold stable while instr_valid=1.
- **Wrap-around:** pointers wrap modulo 4. fetch_addr and instr_pc wrap modulo 2^ADDR_WIDTH with no error.

Optional Feature:
- Macro: RVC_SUPPORT_EN.
- When defined: full behaviour above.
- When undefined:
  - The FIFO logic is removed and each accepted word is presented directly as a 32-bit instruction via a single-word register.
  - is_compressed is tied to 0 and instr_pc steps by 4.
  - flush_pc[1] is ignored and treated as 0.
  - fetch_ready = !word_valid || instr_ready.

Test Plan:
- **Aligned 32-bit stream:** words 0x00A00093, 0x00108113 at 0x0 and 0x4 -> two outputs, pc 0x0 then 0x4, is_compressed=0, first valid one cycle after accept.
- **Mixed straddle:** word0=0x00934529, word1=0x452900A0 -> outputs 0x00004529@0x0 (c=1), 0x00A00093@0x2 (c=0), 0x00004529@0x6 (c=1).
- **Misaligned flush:** flush with flush_pc=0x102 -> fetch_addr=0x100; word 0x4529ABCD at 0x100 yields only 0x00004529@0x102, and 0xABCD is never emitted.
- **Backpressure:** hold instr_ready=0 while supplying all-compressed words -> count saturates at 4, fetch_ready=0 and outputs stable; releasing ready drains in order with pc +2 per cycle.
- **Flush collides with fetch:** assert flush and fetch_valid in the same cycle -> that fetch_data is dropped, instr_valid=0 for two cycles, next output pc = flush_pc.
- **Reset mid-straddle:** reset with count==1, head 0x0093 -> instr_valid=0, instr_pc=RESET_PC, fetch_addr=RESET_PC word address, no stale halfword emitted afterwards.
